mux_rr_arbiter: RTL and testbench

- Shares one 2:1 select datapath between two requesters (A, B) using round-robin arbitration with a bounded burst length.
- Owns the select line, the grants and a registered output stage, so downstream logic sees one valid/data stream.
- Sits directly in front of the shared output path and replaces free-running manual control of the select.

---
 rtl/mux_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: two requesters share one 2:1 select datapath.
// Round-robin grant with a bounded burst length; grants, select and the
// output word are all registered so downstream sees one valid/data stream.
module mux_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 4    // legal range 1..255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  sel,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  out_valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  // Burst length limit expressed as the last legal hold_cnt value.
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_e                  state_q, state_d;
  logic [7:0]              hold_q, hold_d;
  logic                    last_b_q, last_b_d;   // 1: B was granted most recently
  logic                    sel_q, sel_d;
  logic                    gnt_a_q, gnt_b_q;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    xfer_a_s, xfer_b_s;

  assign xfer_a_s = gnt_a_q & req_a;
  assign xfer_b_s = gnt_b_q & req_b;

  // Next-state selection: round-robin in IDLE, release or forced hand-over in a grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          state_d = last_b_q ? GRANT_A : GRANT_B;
        end else if (req_a) begin
          state_d = GRANT_A;
        end else if (req_b) begin
          state_d = GRANT_B;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT_A: begin
        if (!req_a) begin
          state_d = req_b ? GRANT_B : IDLE;
        end else if (req_b && (hold_q == HOLD_LIMIT)) begin
          state_d = GRANT_B;
        end else begin
          state_d = GRANT_A;
        end
      end
      GRANT_B: begin
        if (!req_b) begin
          state_d = req_a ? GRANT_A : IDLE;
        end else if (req_a && (hold_q == HOLD_LIMIT)) begin
          state_d = GRANT_A;
        end else begin
          state_d = GRANT_B;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Burst bookkeeping: entry into a grant restarts the count and moves select/last_grant.
  always_comb begin
    hold_d   = hold_q;
    last_b_d = last_b_q;
    sel_d    = sel_q;
    if (state_d == IDLE) begin
      hold_d = 8'd0;
    end else if (state_d != state_q) begin
      hold_d   = 8'd0;
      last_b_d = (state_d == GRANT_B);
      sel_d    = (state_d == GRANT_B);
    end else if (hold_q < HOLD_LIMIT) begin
      // Staying in the same grant; saturate so a lone requester keeps it.
      hold_d = hold_q + 8'd1;
    end else begin
      hold_d = hold_q;
    end
  end

  // Output stage: capture the word of the current transfer cycle.
  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (xfer_a_s) begin
      out_d       = data_a;
      out_valid_d = 1'b1;
    end else if (xfer_b_s) begin
      out_d       = data_b;
      out_valid_d = 1'b1;
    end else begin
      out_d       = out_q;
      out_valid_d = 1'b0;
    end
  end

  // State and output registers; reset aborts any burst and suppresses its output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= 8'd0;
      last_b_q    <= 1'b1;
      sel_q       <= 1'b0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      last_b_q    <= last_b_d;
      sel_q       <= sel_d;
      gnt_a_q     <= (state_d == GRANT_A);
      gnt_b_q     <= (state_d == GRANT_B);
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign sel       = sel_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a driver issues per-cycle stimulus and
// pushes the reference model's expected outputs; a monitor pops and compares.
module tb_mux_rr_arbiter;

  localparam int DW = 8;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_a = 1'b0, req_b = 1'b0;
  logic [DW-1:0] data_a = '0, data_b = '0;
  logic          gnt_a, gnt_b, sel, out_valid;
  logic [DW-1:0] out;

  mux_rr_arbiter #(.DATA_WIDTH(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
    .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ga;
    logic          gb;
    logic          sl;
    logic          v;
    logic [DW-1:0] o;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;

  // Reference model: owner 0 = nobody, 1 = A, 2 = B; run = cycles held so far.
  int            m_owner = 0;
  int            m_run   = 0;
  int            m_last  = 2;
  logic          m_sel   = 1'b0;
  logic [DW-1:0] m_out   = '0;
  logic          m_v     = 1'b0;

  // Drive one cycle of inputs, advance the model across the coming edge, queue expectation.
  task automatic cyc(input logic r, input logic ra, input logic rb,
                     input logic [DW-1:0] da, input logic [DW-1:0] db);
    int   nxt;
    logic mine, other;
    exp_t e;
    @(negedge clk);
    rst = r; req_a = ra; req_b = rb; data_a = da; data_b = db;
    if (r) begin
      m_owner = 0; m_run = 0; m_last = 2; m_sel = 1'b0; m_out = '0; m_v = 1'b0;
    end else begin
      // Word moved this cycle appears after the edge.
      if (m_owner == 1 && ra) begin
        m_out = da; m_v = 1'b1;
      end else if (m_owner == 2 && rb) begin
        m_out = db; m_v = 1'b1;
      end else begin
        m_v = 1'b0;
      end
      mine  = (m_owner == 1) ? ra : rb;
      other = (m_owner == 1) ? rb : ra;
      if (m_owner == 0) begin
        if (ra && rb)  nxt = (m_last == 2) ? 1 : 2;
        else if (ra)   nxt = 1;
        else if (rb)   nxt = 2;
        else           nxt = 0;
      end else if (!mine) begin
        nxt = other ? (3 - m_owner) : 0;
      end else if (other && m_run >= MH) begin
        nxt = 3 - m_owner;
      end else begin
        nxt = m_owner;
      end
      if (nxt == 0) begin
        m_run = 0;
      end else if (nxt != m_owner) begin
        m_run = 1; m_last = nxt; m_sel = (nxt == 2);
      end else begin
        m_run = m_run + 1;
      end
      m_owner = nxt;
    end
    e.ga = (m_owner == 1);
    e.gb = (m_owner == 2);
    e.sl = m_sel;
    e.v  = m_v;
    e.o  = m_out;
    q.push_back(e);
  endtask

  // Monitor: after every rising edge compare the DUT outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (gnt_a !== e.ga || gnt_b !== e.gb || sel !== e.sl ||
            out_valid !== e.v || out !== e.o) begin
          miscompares++;
          $display("FAIL outputs cycle %0d: got ga=%0b gb=%0b sel=%0b v=%0b out=%02h, required ga=%0b gb=%0b sel=%0b v=%0b out=%02h",
                   cycle, gnt_a, gnt_b, sel, out_valid, out, e.ga, e.gb, e.sl, e.v, e.o);
        end
      end
    end
  end

  // Driver: directed scenarios first, then randomized traffic with occasional resets.
  initial begin
    logic ra, rb, r;
    int   pa, pb;
    // Reset then idle
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    // Single requester A
    cyc(1'b0, 1'b1, 1'b0, 8'h11, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h22, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h33, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h44, 8'h00);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    // Tie with both held high: 4-word blocks alternating
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1, 1'b1, 8'(8'hA0 + i), 8'(8'hB0 + i));
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    // Early release by A while B waits
    cyc(1'b0, 1'b1, 1'b0, 8'h51, 8'h00);
    cyc(1'b0, 1'b1, 1'b1, 8'h52, 8'h61);
    cyc(1'b0, 1'b1, 1'b1, 8'h53, 8'h62);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'(8'h63 + i));
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    // Lone requester B past the limit, then A arrives
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'(8'hC0 + i));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 8'(8'hD0 + i), 8'(8'hCA + i));
    // Reset mid-burst during GRANT_B, then tie goes to A
    repeat (2) cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'hE1);
    cyc(1'b1, 1'b0, 1'b1, 8'h00, 8'hE2);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 8'(8'hF0 + i), 8'(8'hE3 + i));
    // Randomized traffic with varying request densities
    for (int blk = 0; blk < 12; blk++) begin
      pa = $urandom_range(10, 100);
      pb = $urandom_range(10, 100);
      for (int i = 0; i < 50; i++) begin
        ra = ($urandom_range(1, 100) <= pa);
        rb = ($urandom_range(1, 100) <= pb);
        r  = ($urandom_range(0, 199) == 0);
        cyc(r, ra, rb, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
    end
    // Drain the scoreboard with a bounded wait
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
